// File: rtl/ioctl_download_buffer_pkg.sv
// Shared types for the ioctl download buffer: FSM states, FIFO entry layout, checksum width.
package dl_pkg;

  localparam int unsigned DL_ADDR_W     = 17;
  localparam int unsigned DL_CHECKSUM_W = 16;

  typedef enum logic [1:0] {
    DL_IDLE,
    DL_LOAD,
    DL_DRAIN,
    DL_DONE
  } dl_state_t;

  typedef struct packed {
    logic [DL_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } dl_entry_t;

  // Replay is only allowed while a download window is being serviced.
  function automatic logic dl_can_pop(dl_state_t s);
    return (s == DL_LOAD) || (s == DL_DRAIN);
  endfunction

endpackage

// File: rtl/ioctl_download_buffer_if.sv
// Host-side ioctl signals and system-side dn_* loader signals of the download buffer.
interface ioctl_download_buffer_if #(
  parameter int unsigned ADDR_W = 17
);

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;

  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic [7:0]        dn_index;
  logic              dn_busy;
  logic              dn_done;
  logic              dn_overflow;
  logic [15:0]       dn_checksum;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait,
    input  dn_addr, dn_data, dn_wr, dn_index, dn_busy, dn_done, dn_overflow, dn_checksum
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait,
    output dn_addr, dn_data, dn_wr, dn_index, dn_busy, dn_done, dn_overflow, dn_checksum
  );

endinterface

// File: rtl/ioctl_download_buffer_fifo.sv
// dl_fifo: single-clock FIFO with registered read data that holds until the next pop.
module dl_fifo
  import dl_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter type         entry_t = dl_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 wr_data,
  input  logic                   pop,
  output entry_t                 rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly PTR_W bits, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ioctl_download_buffer.sv
// Buffers ioctl download bytes and replays them to the system loader at a clock-enable rate.
// Optional: define DL_CHECKSUM_EN to compute a running 16-bit sum of replayed bytes.
module ioctl_download_buffer
  import dl_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ce_drain,
  ioctl_download_buffer_if.slave   bus
);

  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  dl_state_t         state;
  dl_state_t         state_nxt;
  logic              dl_start;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            rd_entry;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              dn_wr_q;
  logic              wait_q;
  logic              overflow_q;
  logic [7:0]        index_q;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.ioctl_addr[24:ADDR_W];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= DL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dl_start  = 1'b0;
    case (state)
      DL_IDLE: begin
        if (bus.ioctl_download) begin
          state_nxt = DL_LOAD;
          dl_start  = 1'b1;
        end
      end
      DL_LOAD: begin
        if (!bus.ioctl_download) begin
          state_nxt = DL_DRAIN;
        end
      end
      DL_DRAIN: begin
        // The last replayed byte is still on dn_wr this cycle; finish one cycle later.
        if (fifo_empty && !dn_wr_q) begin
          state_nxt = DL_DONE;
        end
      end
      DL_DONE: begin
        state_nxt = DL_IDLE;
      end
      default: begin
        state_nxt = DL_IDLE;
      end
    endcase
  end

  assign push     = (state == DL_LOAD) && bus.ioctl_wr;
  assign pop      = ce_drain && !fifo_empty && dl_can_pop(state);
  assign wr_entry = '{addr: bus.ioctl_addr[ADDR_W-1:0], data: bus.ioctl_dout};

  dl_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dn_wr_q    <= 1'b0;
      wait_q     <= 1'b0;
      overflow_q <= 1'b0;
      index_q    <= '0;
    end else begin
      dn_wr_q <= pop;
      wait_q  <= (fifo_count >= AFULL_LVL);
      if (dl_start) begin
        index_q    <= bus.ioctl_index;
        overflow_q <= 1'b0;
      end else if (push && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [DL_CHECKSUM_W-1:0] csum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (dl_start) begin
      csum_q <= '0;
    end else if (dn_wr_q) begin
      csum_q <= csum_q + DL_CHECKSUM_W'(rd_entry.data);
    end
  end

  assign bus.dn_checksum = csum_q;
`else
  assign bus.dn_checksum = '0;
`endif

  assign bus.ioctl_wait  = wait_q;
  assign bus.dn_addr     = rd_entry.addr;
  assign bus.dn_data     = rd_entry.data;
  assign bus.dn_wr       = dn_wr_q;
  assign bus.dn_index    = index_q;
  assign bus.dn_busy     = (state != DL_IDLE);
  assign bus.dn_done     = (state == DL_DONE);
  assign bus.dn_overflow = overflow_q;

endmodule

// File: tb/tb_ioctl_download_buffer.sv
// Scoreboard bench for ioctl_download_buffer: stimulus queues expected replays, a monitor checks dn_wr.
module tb_ioctl_download_buffer;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ce_drain = 1'b0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int dl_cnt = 0;
  int ce_period = 0;
  logic [15:0] exp_sum;
  logic [7:0]  exp_idx;
  logic [24:0] sb_q [$];

  always #5 clk_sys = ~clk_sys;

  ioctl_download_buffer_if #(.ADDR_W(17)) bif ();

  ioctl_download_buffer #(
    .DEPTH        (16),
    .ADDR_W       (17),
    .AFULL_MARGIN (4)
  ) u_dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ce_drain (ce_drain),
    .bus      (bif)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drain clock-enable generator: one pulse every ce_period cycles, 0 disables.
  initial begin
    int cnt = 0;
    forever begin
      tick();
      if (ce_period == 0) begin
        cnt = 0;
        ce_drain = 1'b0;
      end else begin
        ce_drain = (cnt == ce_period - 1);
        cnt = (cnt == ce_period - 1) ? 0 : cnt + 1;
      end
    end
  end

  // Monitor: every replay strobe must match the oldest expected entry.
  always @(negedge clk_sys) begin
    if (reset_n && bif.dn_done) done_cnt++;
    if (reset_n && bif.dn_wr) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got addr=%h data=%h expected no dn_wr", bif.dn_addr, bif.dn_data);
      end else begin
        logic [24:0] e;
        e = sb_q.pop_front();
        if ({bif.dn_addr, bif.dn_data} !== e) begin
          bad++;
          $display("FAIL sb_entry: got addr=%h data=%h expected addr=%h data=%h",
                   bif.dn_addr, bif.dn_data, e[24:8], e[7:0]);
        end
      end
      total++;
      if (bif.dn_busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_during_wr: got %b expected 1", bif.dn_busy);
      end
    end
  end

  task automatic start_dl(input logic [7:0] idx);
    bif.ioctl_index = idx;
    bif.ioctl_download = 1'b1;
    exp_idx = idx;
    exp_sum = '0;
    tick();
    chk("busy_rise", bif.dn_busy, 1);
  endtask

  task automatic end_dl();
    bif.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [24:0] addr, input logic [7:0] data, input bit obey,
                            input bit accept, input logic [16:0] exp_addr);
    int guard = 0;
    while (obey && bif.ioctl_wait && guard < 500) begin
      tick();
      guard++;
    end
    if (guard >= 500) chk("wait_timeout", 1, 0);
    if (accept) begin
      sb_q.push_back({exp_addr, data});
      exp_sum = exp_sum + {8'h00, data};
    end
    bif.ioctl_addr = addr;
    bif.ioctl_dout = data;
    bif.ioctl_wr = 1'b1;
    tick();
    bif.ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input int limit, input logic [15:0] exp_ck);
    int n = 0;
    @(negedge clk_sys);
    while (!bif.dn_done && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    chk("done_seen", bif.dn_done, 1);
    dl_cnt++;
    chk("busy_at_done", bif.dn_busy, 1);
    chk("index", bif.dn_index, exp_idx);
    chk("sb_drained", sb_q.size(), 0);
`ifdef DL_CHECKSUM_EN
    chk("checksum", bif.dn_checksum, exp_ck);
`else
    chk("checksum", bif.dn_checksum, 16'h0000);
`endif
    @(negedge clk_sys);
    chk("busy_after_done", bif.dn_busy, 0);
    chk("done_pulses", done_cnt, dl_cnt);
    tick();
  endtask

  initial begin
    int first_stall;
    bif.ioctl_download = 1'b0;
    bif.ioctl_wr = 1'b0;
    bif.ioctl_addr = '0;
    bif.ioctl_dout = '0;
    bif.ioctl_index = '0;
    repeat (3) tick();
    chk("reset_outputs", {bif.dn_wr, bif.dn_busy, bif.dn_done, bif.dn_overflow, bif.ioctl_wait,
                          bif.dn_addr, bif.dn_data, bif.dn_index, bif.dn_checksum}, 0);
    reset_n = 1'b1;
    tick();

    // 1: eight bytes, slow drain
    ce_period = 12;
    start_dl(8'h21);
    for (int i = 0; i < 8; i++) write_byte(25'(i), 8'hA0 + 8'(i), 1'b1, 1'b1, 17'(i));
    end_dl();
    wait_done(1000, exp_sum);
    chk("no_overflow_t1", bif.dn_overflow, 0);

    // 2: 20-byte burst obeying ioctl_wait, drain off until the first stall
    ce_period = 0;
    first_stall = -1;
    start_dl(8'h02);
    for (int i = 0; i < 20; i++) begin
      if (bif.ioctl_wait && first_stall < 0) begin
        first_stall = i;
        ce_period = 3;
      end
      write_byte(25'h100 + 25'(i), 8'(i * 7 + 3), 1'b1, 1'b1, 17'h100 + 17'(i));
    end
    chk("writes_before_wait", first_stall, 13);
    chk("no_overflow_t2", bif.dn_overflow, 0);
    end_dl();
    wait_done(1000, exp_sum);

    // 3: host ignores ioctl_wait, 17th byte dropped
    ce_period = 0;
    start_dl(8'h03);
    for (int i = 0; i < 17; i++)
      write_byte(25'h200 + 25'(i), 8'h40 + 8'(i), 1'b0, (i < 16), 17'h200 + 17'(i));
    chk("overflow_set", bif.dn_overflow, 1);
    ce_period = 2;
    end_dl();
    wait_done(1000, exp_sum);
    chk("overflow_sticky", bif.dn_overflow, 1);

    // 4: upper address bits discarded
    ce_period = 5;
    start_dl(8'h04);
    write_byte(25'h1A_2345, 8'h5A, 1'b1, 1'b1, 17'h0_2345);
    write_byte(25'h1_2345, 8'hC3, 1'b1, 1'b1, 17'h1_2345);
    write_byte(25'h1FF_FFFF, 8'h11, 1'b1, 1'b1, 17'h1_FFFF);
    end_dl();
    wait_done(1000, exp_sum);
    chk("overflow_cleared", bif.dn_overflow, 0);

    // 5: reset mid-load with five bytes buffered
    ce_period = 0;
    start_dl(8'h55);
    for (int i = 0; i < 5; i++) write_byte(25'h300 + 25'(i), 8'h90 + 8'(i), 1'b1, 1'b1, 17'h300 + 17'(i));
    reset_n = 1'b0;
    #1;
    chk("reset_mid_load", {bif.dn_wr, bif.dn_busy, bif.dn_done, bif.dn_overflow, bif.ioctl_wait,
                           bif.dn_addr, bif.dn_data, bif.dn_index, bif.dn_checksum}, 0);
    sb_q.delete();
    bif.ioctl_download = 1'b0;
    ce_period = 1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    chk("idle_after_reset", bif.dn_busy, 0);
    start_dl(8'h66);
    write_byte(25'h7, 8'h3C, 1'b1, 1'b1, 17'h7);
    write_byte(25'h8, 8'hC3, 1'b1, 1'b1, 17'h8);
    end_dl();
    wait_done(1000, exp_sum);

    // 6: checksum FF+FF+02 wraps into 0x0200
    ce_period = 4;
    start_dl(8'h06);
    write_byte(25'h0, 8'hFF, 1'b1, 1'b1, 17'h0);
    write_byte(25'h1, 8'hFF, 1'b1, 1'b1, 17'h1);
    write_byte(25'h2, 8'h02, 1'b1, 1'b1, 17'h2);
    end_dl();
    wait_done(1000, 16'h0200);

    repeat (5) tick();
    chk("done_total", done_cnt, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
